priority_encoder_8to3: RTL and testbench
========================================

// Module: priority_encoder_8to3
// PURPOSE
//  Registered 8-to-3 priority encoder with enable. Converts an 8-bit request
//  vector into the 3-bit index of its highest set bit, plus valid and multi-hot
//  flags. Used as a generic index encoder in control/arbitration datapaths.
//  All outputs are registered on clk.
// PARAMETERS
//  IN_W   8  width of request vector; must be a power of 2, >= 2
//  OUT_W  3  index width; must equal $clog2(IN_W); elaboration error otherwise
// PORTS
//  clk    in   1      single clock; all state updates on rising edge
//  rst    in   1      reset, synchronous, active-high
//  en     in   1      encode enable
//  in     in   IN_W   request vector; any bit pattern legal, including multi-hot
//  out    out  OUT_W  registered index of highest set bit of in
//  valid  out  1      registered: en && (in != 0)
//  multi  out  1      registered: en && more than one bit of in set
// BEHAVIOUR
//  - Reset: rst=1 at a rising clk edge -> out=0, valid=0, multi=0 next cycle.
//    rst has priority over en; rst asserted mid-stream discards that cycle's input.
//  - Latency: exactly 1 cycle. Inputs sampled at edge N appear on outputs after
//    edge N. No handshake, no backpressure. A new encode is accepted every cycle.
//  - en=1: out <= index i of the highest set bit of in (MSB wins, bit 7 highest).
//    valid <= |in. multi <= (popcount(in) > 1).
//  - en=1, in=0: out <= 0, valid <= 0, multi <= 0 (out=0 is ambiguous with
//    in[0]=1; consumers qualify out with valid).
//  - en=0: out <= 0, valid <= 0, multi <= 0 regardless of in.
//  - No hold behaviour: outputs always reflect the previous cycle's inputs.
//  - Outputs never X after the first reset edge. X on in while en=0 must not
//    propagate to outputs.
//  - No state beyond the output registers; no FSM.
//  - Arithmetic: index computed as an unsigned OUT_W value; popcount is
//    $clog2(IN_W)+1 bits wide so that all-ones does not overflow.
// STRUCTURE
//  - Package encoder_pkg: localparams ENC_IN_W=8, ENC_OUT_W=3 and a function
//    f_msb_index(logic [ENC_IN_W-1:0]) returning the highest-set-bit index.
//  - One combinational sub-module priority_enc_core (in -> idx, any, multi);
//    the top level adds the en gating and the output register stage with
//    synchronous reset.
// TESTING
//  - rst=1 for 2 edges with en=1, in=8'hFF -> out=0, valid=0, multi=0.
//  - en=1, in=8'b0000_1000 -> next cycle out=3'd3, valid=1, multi=0;
//    in=8'h01 -> out=0, valid=1.
//  - en=1, in=8'b1111_1001 -> out=3'd7, valid=1, multi=1;
//    in=8'b0000_0110 -> out=3'd2, multi=1.
//  - en=0, in=8'h80 -> out=0, valid=0, multi=0; en=1, in=8'h00 -> out=0, valid=0.
//  - Back-to-back: in=8'h10, 8'h02, 8'h40 on consecutive edges with en=1 ->
//    out sequence 4, 1, 6, each one cycle late.
//  - Random: 1000 cycles of random en/in, with rst pulsed mid-run -> outputs
//    match a reference model (MSB index, |in, popcount>1, gated by en, reset to 0).

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared widths and the reference highest-set-bit function for the 8-to-3
// priority encoder.
package encoder_pkg;

  localparam int ENC_IN_W  = 8;
  localparam int ENC_OUT_W = 3;

  // Index of the highest set bit; an all-zero vector yields 0, so callers
  // must qualify the result with a separate "any bit set" flag.
  function automatic logic [ENC_OUT_W-1:0] f_msb_index(input logic [ENC_IN_W-1:0] vec);
    logic [ENC_OUT_W-1:0] idx;
    idx = '0;
    // Ascending scan: later (higher) set bits overwrite earlier ones, so the MSB wins.
    for (int i = 0; i < ENC_IN_W; i++) begin
      if (vec[i]) idx = ENC_OUT_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/priority_enc_core.sv
// Combinational priority encoder core: highest-set-bit index, any-set flag and
// multi-hot flag for a request vector.
module priority_enc_core
  import encoder_pkg::*;
#(
  parameter int IN_W  = ENC_IN_W,
  parameter int OUT_W = ENC_OUT_W
) (
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] idx,
  output logic             any,
  output logic             multi
);

  // One extra bit so that an all-ones vector does not wrap the count.
  localparam int CNT_W = $clog2(IN_W) + 1;

  logic [CNT_W-1:0] w_popcount;

  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first; a path that skips the assignment would infer a latch.
    w_popcount = '0;
    for (int i = 0; i < IN_W; i++) begin
      w_popcount = w_popcount + CNT_W'(in[i]);
    end
  end

  assign any   = |in;
  assign multi = (w_popcount > CNT_W'(1));

  generate
    if (IN_W == ENC_IN_W) begin : g_pkg_index
      assign idx = f_msb_index(in);
    end else begin : g_generic_index
      always_comb begin
        idx = '0;
        for (int i = 0; i < IN_W; i++) begin
          if (in[i]) idx = OUT_W'(i);
        end
      end
    end
  endgenerate

endmodule

// File: rtl/priority_encoder_8to3.sv
// Registered 8-to-3 priority encoder with enable: index of the highest set
// request bit plus valid and multi-hot flags, one cycle after sampling.
module priority_encoder_8to3
  import encoder_pkg::*;
#(
  parameter int IN_W  = ENC_IN_W,
  parameter int OUT_W = ENC_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IN_W-1:0]  in,
  output logic [OUT_W-1:0] out,
  output logic             valid,
  output logic             multi
);

  generate
    if ((IN_W < 2) || ((IN_W & (IN_W - 1)) != 0)) begin : g_bad_in_w
      $error("priority_encoder_8to3: IN_W must be a power of 2 and >= 2");
    end
    if (OUT_W != $clog2(IN_W)) begin : g_bad_out_w
      $error("priority_encoder_8to3: OUT_W must equal $clog2(IN_W)");
    end
  endgenerate

  logic [OUT_W-1:0] w_idx;
  logic             w_any;
  logic             w_multi;

  logic [OUT_W-1:0] r_out;
  logic             r_valid;
  logic             r_multi;

  priority_enc_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in    (in),
    .idx   (w_idx),
    .any   (w_any),
    .multi (w_multi)
  );

  // With en low the core results are never selected, so X on the request
  // vector cannot reach the registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_multi <= 1'b0;
    end else if (en) begin
      r_out   <= w_idx;
      r_valid <= w_any;
      r_multi <= w_multi;
    end else begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_multi <= 1'b0;
    end
  end

  assign out   = r_out;
  assign valid = r_valid;
  assign multi = r_multi;

endmodule

// File: tb/tb_priority_encoder_8to3.sv
// Directed and random checks of the registered 8-to-3 priority encoder.
module tb_priority_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] in_v;
  logic [2:0] out;
  logic       valid;
  logic       multi;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  priority_encoder_8to3 dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .in    (in_v),
    .out   (out),
    .valid (valid),
    .multi (multi)
  );

  // Advance one active edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    en   = 1'b1;
    in_v = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if ({out, valid, multi} !== 5'b000_0_0) begin
        n_errors++;
        $display("FAIL reset_edge%0d: got out=%0d valid=%b multi=%b, want out=0 valid=0 multi=0",
                 k, out, valid, multi);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_single_hot();
    logic [7:0] vec [3] = '{8'b0000_1000, 8'h01, 8'h80};
    logic [2:0] exp [3] = '{3'd3, 3'd0, 3'd7};
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_v = vec[k];
      tick();
      n_checks++;
      if ({out, valid, multi} !== {exp[k], 1'b1, 1'b0}) begin
        n_errors++;
        $display("FAIL single_hot in=%h: got out=%0d valid=%b multi=%b, want out=%0d valid=1 multi=0",
                 vec[k], out, valid, multi, exp[k]);
      end
    end
  endtask

  task automatic test_multi_hot();
    logic [7:0] vec [4] = '{8'b1111_1001, 8'b0000_0110, 8'hFF, 8'h03};
    logic [2:0] exp [4] = '{3'd7, 3'd2, 3'd7, 3'd1};
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_v = vec[k];
      tick();
      n_checks++;
      if ({out, valid, multi} !== {exp[k], 1'b1, 1'b1}) begin
        n_errors++;
        $display("FAIL multi_hot in=%h: got out=%0d valid=%b multi=%b, want out=%0d valid=1 multi=1",
                 vec[k], out, valid, multi, exp[k]);
      end
    end
  endtask

  task automatic test_disable_and_zero();
    logic       en_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] vec    [4] = '{8'h80, 8'h00, 8'hxx, 8'hFF};
    for (int k = 0; k < 4; k++) begin
      en   = en_tab[k];
      in_v = vec[k];
      tick();
      n_checks++;
      if ({out, valid, multi} !== 5'b000_0_0) begin
        n_errors++;
        $display("FAIL gated_or_zero case%0d en=%b in=%h: got out=%0d valid=%b multi=%b, want all 0",
                 k, en_tab[k], vec[k], out, valid, multi);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vec [3] = '{8'h10, 8'h02, 8'h40};
    logic [2:0] exp [3] = '{3'd4, 3'd1, 3'd6};
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_v = vec[k];
      tick();
      n_checks++;
      if ({out, valid, multi} !== {exp[k], 1'b1, 1'b0}) begin
        n_errors++;
        $display("FAIL back_to_back step%0d: got out=%0d valid=%b multi=%b, want out=%0d valid=1 multi=0",
                 k, out, valid, multi, exp[k]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    en   = 1'b1;
    in_v = 8'h84;
    rst  = 1'b1;
    tick();
    n_checks++;
    if ({out, valid, multi} !== 5'b000_0_0) begin
      n_errors++;
      $display("FAIL reset_midstream: got out=%0d valid=%b multi=%b, want all 0", out, valid, multi);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if ({out, valid, multi} !== {3'd7, 1'b1, 1'b1}) begin
      n_errors++;
      $display("FAIL after_reset: got out=%0d valid=%b multi=%b, want out=7 valid=1 multi=1",
               out, valid, multi);
    end
  endtask

  task automatic test_random();
    logic [2:0] m_out;
    logic       m_valid;
    logic       m_multi;
    for (int c = 0; c < 1000; c++) begin
      rst  = (c >= 400 && c < 403);
      en   = ($urandom_range(0, 3) != 0);
      in_v = 8'($urandom_range(0, 255));
      // Reference: scan down from bit 7 and stop at the first set bit.
      m_out   = 3'd0;
      m_valid = 1'b0;
      m_multi = 1'b0;
      if (!rst && en) begin
        for (int b = 7; b >= 0; b--) begin
          if (in_v[b]) begin
            m_out = 3'(b);
            break;
          end
        end
        m_valid = (in_v != 8'h00);
        m_multi = ($countones(in_v) > 1);
      end
      tick();
      n_checks++;
      if ({out, valid, multi} !== {m_out, m_valid, m_multi}) begin
        n_errors++;
        $display("FAIL random cycle%0d rst=%b en=%b in=%h: got out=%0d valid=%b multi=%b, want out=%0d valid=%b multi=%b",
                 c, rst, en, in_v, out, valid, multi, m_out, m_valid, m_multi);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b0;
    en   = 1'b0;
    in_v = 8'h00;
    test_reset();
    test_single_hot();
    test_multi_hot();
    test_disable_and_zero();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
